blink_meter: RTL and testbench
==============================

Name: blink_meter

Overview:
- Receive-side counterpart of the display blink generator: samples an asynchronous blink/pulse line and measures the on (high) and off (low) durations of each period in clk cycles.
- Reports each completed period with a one-cycle valid strobe and checks it against the expected on/off durations within a tolerance.
- Flags loss of activity with a timeout.
- Used for self-check of cursor/attribute blink timing and for external blink inputs.

Parameters:
- CNT_WIDTH, 32, width of duration counters and measurement outputs.
- EXP_ON, 25_000_000, expected high duration in cycles.
- EXP_OFF, 25_000_000, expected low duration in cycles.
- TOLERANCE, 1000, allowed absolute deviation (cycles) per phase for in_spec.
- TIMEOUT, 100_000_000, cycles without an edge before declaring stall; must be < 2^CNT_WIDTH.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- blink_in  input  1  asynchronous blink signal to measure.
- meas_on  output  CNT_WIDTH  last measured high duration.
- meas_off  output  CNT_WIDTH  last measured low duration.
- meas_valid  output  1  one-cycle pulse when meas_on/meas_off update.
- in_spec  output  1  last measurement within tolerance on both phases.
- locked  output  1  two consecutive in-spec measurements, no timeout since.
- stalled  output  1  timeout occurred, no rising edge since.

Behaviour:
- Reset: all outputs 0; counter 0; state IDLE; synchronizer flops and delayed copy cleared to 0.
- Input path: 2-flop synchronizer (s1, s2) plus delayed copy s2_d.
  - rise = s2 & ~s2_d; fall = ~s2 & s2_d.
  - Input-to-detection latency is 2 clk cycles.
- States:
  - IDLE: counter held 0. On rise: counter <= 1, stalled <= 0, go HIGH. Fall is ignored.
  - HIGH: on fall, on_len <= counter, counter <= 1, go LOW. Otherwise counter++.
  - LOW: on rise, publish the period, counter <= 1, go HIGH. Otherwise counter++.
- Publishing a period (LOW + rise):
  - meas_on <= on_len, meas_off <= counter.
  - meas_valid <= 1 for exactly one cycle.
  - in_spec <= (|on_len-EXP_ON| <= TOLERANCE) && (|counter-EXP_OFF| <= TOLERANCE).
- Duration rule: for a clean synchronous input high for N cycles, the measured value is exactly N. Same for low.
- First period after IDLE is the first complete high+low pair. A partial low phase before the first rise is never reported.
- Timeout: in HIGH or LOW, if no edge this cycle and counter == TIMEOUT:
  - go IDLE, counter <= 0.
  - stalled <= 1, locked <= 0, in_spec <= 0, consecutive-pass count <= 0.
  - meas_on/meas_off keep their last values.
- Edge priority: an edge in the same cycle as counter == TIMEOUT takes priority; no timeout.
- locked:
  - 2-bit pass count increments (saturating at 2) on each in-spec publish and clears on an out-of-spec publish.
  - locked = (pass count == 2), registered. It updates in the same cycle as meas_valid.
- Arithmetic:
  - Absolute difference computed in CNT_WIDTH+1 bits; no wrap.
  - Counter cannot overflow because TIMEOUT < 2^CNT_WIDTH.
- Reset mid-measurement: returns to IDLE immediately. Any in-progress on_len is discarded and no meas_valid is issued.
- Glitches: a one-cycle pulse on s2 is measured as a 1-cycle phase; no filtering.

Test Plan:
- Params EXP_ON=5, EXP_OFF=3, TOLERANCE=0, TIMEOUT=20; drive blink_in 5 high/3 low repeatedly -> first meas_valid: meas_on=5, meas_off=3, in_spec=1; locked=1 on second meas_valid.
- Same params, drive 5 high/4 low -> meas_on=5, meas_off=4, in_spec=0, locked stays 0. Switch to 5/3 -> locked=1 only after two in-spec periods.
- Locked, then hold blink_in high -> stalled=1, locked=0, state IDLE when counter hits 20. The next rise clears stalled and the next full period is reported.
- Start with blink_in low 7 cycles, then 5/3 pattern -> leading low is not reported; first meas_valid has meas_off=3.
- Assert reset during the HIGH phase -> no meas_valid, all outputs 0, measurement restarts at the next rise.
- Edge exactly when counter==TIMEOUT (high for 20 cycles with TIMEOUT=20) -> no stall; transition to LOW and on_len=20 recorded.

Source files
------------

// File: rtl/blink_meter.sv
// Blink/pulse line meter: synchronizes an asynchronous blink input, measures each
// high+low period in clk cycles, checks it against expected durations and flags stalls.
module blink_meter #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned EXP_ON    = 25_000_000,
  parameter int unsigned EXP_OFF   = 25_000_000,
  parameter int unsigned TOLERANCE = 1000,
  parameter int unsigned TIMEOUT   = 100_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 blink_in,
  output logic [CNT_WIDTH-1:0] meas_on,
  output logic [CNT_WIDTH-1:0] meas_off,
  output logic                 meas_valid,
  output logic                 in_spec,
  output logic                 locked,
  output logic                 stalled
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // One extra bit so the deviation never wraps, whatever the operands.
  localparam logic [CNT_WIDTH:0]   EXP_ON_X  = (CNT_WIDTH+1)'(EXP_ON);
  localparam logic [CNT_WIDTH:0]   EXP_OFF_X = (CNT_WIDTH+1)'(EXP_OFF);
  localparam logic [CNT_WIDTH:0]   TOL_X     = (CNT_WIDTH+1)'(TOLERANCE);
  localparam logic [CNT_WIDTH-1:0] TO_CNT    = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

  function automatic logic [CNT_WIDTH:0] absdiff(input logic [CNT_WIDTH:0] a,
                                                 input logic [CNT_WIDTH:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_t               state;
  logic                 s1, s2, s2_d;
  logic [CNT_WIDTH-1:0] counter;
  logic [CNT_WIDTH-1:0] on_len;
  logic [1:0]           pass_cnt;

  logic                 rise, fall, expired;
  logic [CNT_WIDTH:0]   on_dev, off_dev;
  logic                 period_ok;
  logic [1:0]           pass_nxt;

  assign rise    = s2 & ~s2_d;
  assign fall    = ~s2 & s2_d;
  assign expired = (counter == TO_CNT);
  assign on_dev  = absdiff({1'b0, on_len}, EXP_ON_X);
  assign off_dev = absdiff({1'b0, counter}, EXP_OFF_X);

  // Evaluated only when a period is published: on_len is complete and counter
  // holds the full low duration at that moment.
  always_comb begin
    period_ok = (on_dev <= TOL_X) && (off_dev <= TOL_X);
    pass_nxt  = 2'd0;
    if (period_ok)
      pass_nxt = (pass_cnt == 2'd2) ? 2'd2 : pass_cnt + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s2_d       <= 1'b0;
      counter    <= '0;
      on_len     <= '0;
      pass_cnt   <= 2'd0;
      meas_on    <= '0;
      meas_off   <= '0;
      meas_valid <= 1'b0;
      in_spec    <= 1'b0;
      locked     <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      s1         <= blink_in;
      s2         <= s1;
      s2_d       <= s2;
      meas_valid <= 1'b0;

      case (state)
        IDLE: begin
          // A leading low phase is never complete, so only a rise starts measuring.
          counter <= '0;
          if (rise) begin
            counter <= ONE;
            stalled <= 1'b0;
            state   <= HIGH;
          end
        end

        HIGH: begin
          if (fall) begin
            on_len  <= counter;
            counter <= ONE;
            state   <= LOW;
          end else if (expired) begin
            counter  <= '0;
            stalled  <= 1'b1;
            locked   <= 1'b0;
            in_spec  <= 1'b0;
            pass_cnt <= 2'd0;
            state    <= IDLE;
          end else begin
            counter <= counter + ONE;
          end
        end

        LOW: begin
          if (rise) begin
            meas_on    <= on_len;
            meas_off   <= counter;
            meas_valid <= 1'b1;
            in_spec    <= period_ok;
            pass_cnt   <= pass_nxt;
            locked     <= (pass_nxt == 2'd2);
            counter    <= ONE;
            state      <= HIGH;
          end else if (expired) begin
            counter  <= '0;
            stalled  <= 1'b1;
            locked   <= 1'b0;
            in_spec  <= 1'b0;
            pass_cnt <= 2'd0;
            state    <= IDLE;
          end else begin
            counter <= counter + ONE;
          end
        end

        default: begin
          counter <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_meter.sv
// Directed bench for blink_meter: expected periods are queued as they are driven
// and compared when meas_valid fires; status flags are checked at fixed points.
module tb_blink_meter;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          blink_in;
  logic [CW-1:0] meas_on, meas_off;
  logic          meas_valid, in_spec, locked, stalled;

  blink_meter #(
    .CNT_WIDTH(CW), .EXP_ON(5), .EXP_OFF(3), .TOLERANCE(0), .TIMEOUT(20)
  ) dut (
    .clk(clk), .reset(reset), .blink_in(blink_in),
    .meas_on(meas_on), .meas_off(meas_off), .meas_valid(meas_valid),
    .in_spec(in_spec), .locked(locked), .stalled(stalled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   on;
    int   off;
    logic ins;
    logic lk;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   pc    = 0;   // model of consecutive in-spec periods

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic phase(input logic lvl, input int n);
    blink_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Drives one high+low period; it is reported once the following rise is seen.
  task automatic period(input int h, input int l);
    exp_t e;
    e.on  = h;
    e.off = l;
    e.ins = (h == 5) && (l == 3);
    pc    = e.ins ? ((pc == 2) ? 2 : pc + 1) : 0;
    e.lk  = (pc == 2);
    sb.push_back(e);
    phase(1'b1, h);
    phase(1'b0, l);
  endtask

  always @(negedge clk) begin
    if (!reset && meas_valid) begin
      chk("valid_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("meas_on",  32'(meas_on),  e.on);
        chk("meas_off", 32'(meas_off), e.off);
        chk("in_spec",  in_spec, e.ins);
        chk("locked",   locked,  e.lk);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    blink_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_meas_on",  32'(meas_on), 0);
    chk("rst_meas_off", 32'(meas_off), 0);
    chk("rst_valid",    meas_valid, 0);
    chk("rst_in_spec",  in_spec, 0);
    chk("rst_locked",   locked, 0);
    chk("rst_stalled",  stalled, 0);
    reset = 1'b0;

    // Leading low phase is not reported; then nominal periods lock.
    phase(1'b0, 7);
    repeat (3) period(5, 3);
    // Out-of-spec low drops the pass count, two good periods relock.
    repeat (2) period(5, 4);
    repeat (2) period(5, 3);

    // Hold high: last period is published, then the timeout fires.
    phase(1'b1, 6);
    chk("locked_before_stall", locked, 1);
    chk("stalled_before", stalled, 0);
    phase(1'b1, 24);
    pc = 0;
    chk("stalled", stalled, 1);
    chk("locked_after_stall", locked, 0);
    chk("in_spec_after_stall", in_spec, 0);
    chk("meas_on_kept", 32'(meas_on), 5);
    chk("meas_off_kept", 32'(meas_off), 3);
    chk("sb_drain_stall", sb.size(), 0);

    // Recovery: the fall in IDLE is ignored, the next rise clears stalled.
    phase(1'b0, 4);
    period(5, 3);
    chk("stalled_cleared", stalled, 0);
    // High for exactly TIMEOUT cycles: the fall wins over the timeout.
    period(20, 3);
    period(5, 3);
    phase(1'b1, 4);
    chk("no_stall_at_edge", stalled, 0);
    chk("sb_drain_edge", sb.size(), 0);

    // Reset in the middle of a high phase discards the measurement.
    reset    = 1'b1;
    blink_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pc    = 0;
    phase(1'b0, 3);
    chk("mid_rst_meas_on", 32'(meas_on), 0);
    chk("mid_rst_meas_off", 32'(meas_off), 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_in_spec", in_spec, 0);
    chk("mid_rst_stalled", stalled, 0);
    repeat (2) period(5, 3);
    phase(1'b1, 5);
    chk("sb_drain_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
